// File: rtl/conv_window_mac.sv
// 3x3 convolution window MAC: column-wise window fill with row-start handling,
// a registered nine-product stage and a registered sum stage (latency 2).
//
// Handshake: a column is accepted when in_valid & en & ~w_load; there is no
// ready, nothing stalls, and out_valid is a one-cycle pulse per result.
module conv_window_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [3*DATA_W-1:0]   in_col,
  input  logic [31:0]           in_addr,
  input  logic                  row_start,
  input  logic                  w_load,
  input  logic [9*DATA_W-1:0]   w_data,
  output logic                  out_valid,
  output logic [ACC_W-1:0]      out_data,
  output logic [31:0]           out_addr,
  output logic [1:0]            dbg_cnt
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } cnt_e;

  cnt_e                     cnt_q, cnt_d;
  logic [3*DATA_W-1:0]      win_q [3];
  logic [3*DATA_W-1:0]      win_d [3];
  logic [9*DATA_W-1:0]      w_q, w_d;
  logic signed [PW-1:0]     prod_q [9];
  logic signed [PW-1:0]     prod_d [9];
  logic                     s1_valid_q, s1_valid_d;
  logic [31:0]              s1_addr_q, s1_addr_d;
  logic                     out_valid_q, out_valid_d;
  logic [ACC_W-1:0]         out_data_q, out_data_d;
  logic [31:0]              out_addr_q, out_addr_d;

  logic                     accept;
  logic                     fire;
  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] wt;
  logic signed [ACC_W-1:0]  sum;

  always_comb begin
    accept     = in_valid & en & ~w_load;
    cnt_d      = cnt_q;
    w_d        = w_q;
    for (int c = 0; c < 3; c++) win_d[c] = win_q[c];

    if (w_load) begin
      w_d   = w_data;
      cnt_d = EMPTY;
    end else if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = in_col;
      if (row_start)        cnt_d = ONE;
      else if (cnt_q != FULL) cnt_d = cnt_e'(cnt_q + 2'd1);
    end

    // A row start never fires, even from FULL: the old columns are discarded.
    fire = accept & ~row_start & ((cnt_q == TWO) | (cnt_q == FULL));

    pix        = '0;
    wt         = '0;
    s1_valid_d = fire;
    s1_addr_d  = s1_addr_q;
    for (int k = 0; k < 9; k++) prod_d[k] = prod_q[k];
    if (fire) begin
      s1_addr_d = in_addr;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          pix = win_d[c][r*DATA_W +: DATA_W];
          wt  = w_q[(r*3+c)*DATA_W +: DATA_W];
          prod_d[r*3+c] = PW'(pix) * PW'(wt);
        end
      end
    end

    sum = '0;
    for (int k = 0; k < 9; k++) sum = sum + ACC_W'(prod_q[k]);

    out_valid_d = s1_valid_q;
    out_data_d  = s1_valid_q ? sum       : out_data_q;
    out_addr_d  = s1_valid_q ? s1_addr_q : out_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= EMPTY;
      w_q         <= '0;
      for (int c = 0; c < 3; c++) win_q[c] <= '0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      for (int c = 0; c < 3; c++) win_q[c] <= win_d[c];
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: directed scenarios plus random traffic, checked
// against a column-history reference model and an expected-result queue.
module tb_conv_window_mac;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                in_valid;
  logic [3*DATA_W-1:0] in_col;
  logic [31:0]         in_addr;
  logic                row_start;
  logic                w_load;
  logic [9*DATA_W-1:0] w_data;
  logic                out_valid;
  logic [ACC_W-1:0]    out_data;
  logic [31:0]         out_addr;
  logic [1:0]          dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // clock / reset
  always #5 clk = ~clk;

  conv_window_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_col    (in_col),
    .in_addr   (in_addr),
    .row_start (row_start),
    .w_load    (w_load),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .dbg_cnt   (dbg_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] mk_col(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [71:0] mk_w_all(input int v);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v);
    return w;
  endfunction

  function automatic int pix(input logic [23:0] col, input int r);
    return int'($signed(col[r*8 +: 8]));
  endfunction

  // reference model: columns of the current row, weights, expected results
  logic [23:0] cols_q[$];
  int          wt[9];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          exp_due_q[$];
  logic [31:0] obs_data_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] last_data, last_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_q.delete();
      exp_q.delete();
      exp_addr_q.delete();
      exp_due_q.delete();
      for (int k = 0; k < 9; k++) wt[k] = 0;
    end else begin
      cyc++;
      if (w_load) begin
        for (int k = 0; k < 9; k++) wt[k] = int'($signed(w_data[k*8 +: 8]));
        cols_q.delete();
      end else if (in_valid && en) begin
        int acc;
        if (row_start) cols_q.delete();
        cols_q.push_back(in_col);
        if (cols_q.size() > 3) void'(cols_q.pop_front());
        if (cols_q.size() == 3) begin
          acc = 0;
          for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
              acc += pix(cols_q[c], r) * wt[r*3+c];
          exp_q.push_back(32'(acc));
          exp_addr_q.push_back(in_addr);
          exp_due_q.push_back(cyc + 1);
        end
      end
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_addr", out_addr, 0);
      check("rst_cnt", dbg_cnt, 0);
      last_data = 0;
      last_addr = 0;
    end else begin
      logic exp_v;
      exp_v = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
        last_data = exp_q.pop_front();
        last_addr = exp_addr_q.pop_front();
        void'(exp_due_q.pop_front());
        check("out_data", out_data, last_data);
        check("out_addr", out_addr, last_addr);
      end else begin
        check("hold_data", out_data, last_data);
        check("hold_addr", out_addr, last_addr);
      end
      if (out_valid) begin
        obs_data_q.push_back(out_data);
        obs_addr_q.push_back(out_addr);
      end
    end
  end

  // driver tasks
  task automatic col(input logic [23:0] c, input logic [31:0] a, input logic rs);
    @(posedge clk); #1;
    en = 1'b1; in_valid = 1'b1; w_load = 1'b0;
    in_col = c; in_addr = a; row_start = rs;
  endtask

  task automatic load_w(input logic [71:0] w, input logic with_col);
    @(posedge clk); #1;
    en = 1'b1; w_load = 1'b1; w_data = w;
    in_valid = with_col; in_col = mk_col(9, 9, 9); in_addr = 32'hdead; row_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; w_load = 1'b0; row_start = 1'b0; en = 1'b1;
    end
  endtask

  task automatic clear_obs();
    obs_data_q.delete();
    obs_addr_q.delete();
  endtask

  initial begin
    logic [71:0] w;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_col = '0; in_addr = '0;
    row_start = 1'b0; w_load = 1'b0; w_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // all-ones kernel, two overlapping windows back to back
    clear_obs();
    load_w(mk_w_all(1), 1'b0);
    col(mk_col(1, 2, 3), 32'h10, 1'b0);
    col(mk_col(4, 5, 6), 32'h11, 1'b0);
    col(mk_col(7, 8, 9), 32'h12, 1'b0);
    col(mk_col(10, 11, 12), 32'h13, 1'b0);
    idle(4);
    check("s1_count", obs_data_q.size(), 2);
    check("s1_data0", obs_data_q[0], 45);
    check("s1_addr0", obs_addr_q[0], 32'h12);
    check("s1_data1", obs_data_q[1], 72);
    check("s1_addr1", obs_addr_q[1], 32'h13);

    // negative center weight and most negative pixel
    clear_obs();
    w = '0;
    w[4*8 +: 8] = 8'hFF;
    load_w(w, 1'b0);
    col(mk_col(0, 0, 0), 32'h20, 1'b0);
    col(mk_col(0, -128, 0), 32'h21, 1'b0);
    col(mk_col(0, 0, 0), 32'h22, 1'b0);
    idle(4);
    check("neg_count", obs_data_q.size(), 1);
    check("neg_data", obs_data_q[0], 128);

    // row start on the 4th column restarts the fill
    clear_obs();
    load_w(mk_w_all(1), 1'b0);
    for (int n = 1; n <= 6; n++) col(mk_col(n, n, n), 32'h30 + 32'(n), n == 4);
    idle(4);
    check("row_count", obs_data_q.size(), 2);
    check("row_data0", obs_data_q[0], 18);
    check("row_data1", obs_data_q[1], 45);
    check("row_addr1", obs_addr_q[1], 32'h36);

    // weight load collides with a column
    clear_obs();
    load_w(mk_w_all(2), 1'b0);
    col(mk_col(5, 5, 5), 32'h40, 1'b0);
    col(mk_col(6, 6, 6), 32'h41, 1'b0);
    load_w(mk_w_all(2), 1'b1);
    idle(1);
    check("wl_cnt", dbg_cnt, 0);
    col(mk_col(1, 1, 1), 32'h42, 1'b0);
    col(mk_col(2, 2, 2), 32'h43, 1'b0);
    idle(3);
    check("wl_quiet", obs_data_q.size(), 0);
    col(mk_col(3, 3, 3), 32'h44, 1'b0);
    idle(4);
    check("wl_count", obs_data_q.size(), 1);
    check("wl_data", obs_data_q[0], 36);
    check("wl_addr", obs_addr_q[0], 32'h44);

    // reset one cycle after a fire discards the in-flight result
    clear_obs();
    load_w(mk_w_all(1), 1'b0);
    col(mk_col(1, 2, 3), 32'h50, 1'b0);
    col(mk_col(4, 5, 6), 32'h51, 1'b0);
    col(mk_col(7, 8, 9), 32'h52, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    check("rst_drop", obs_data_q.size(), 0);
    load_w(mk_w_all(1), 1'b0);
    col(mk_col(1, 2, 3), 32'h50, 1'b0);
    col(mk_col(4, 5, 6), 32'h51, 1'b0);
    col(mk_col(7, 8, 9), 32'h52, 1'b0);
    idle(4);
    check("rst_count", obs_data_q.size(), 1);
    check("rst_data", obs_data_q[0], 45);
    check("rst_addr", obs_addr_q[0], 32'h52);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      w_load    = ($urandom_range(0, 24) == 0);
      w_data    = {$urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      row_start = ($urandom_range(0, 9) == 0);
      in_col    = 24'($urandom);
      in_addr   = $urandom;
    end
    idle(5);
    check("drain", exp_due_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, giving the signed pixel and weight width.
REQ-002 The block SHALL have a parameter ACC_W, default 32, giving the signed result width; ACC_W >= 2*DATA_W+4.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have a port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have a port en, input, 1 bit: input enable; when low, in_valid is ignored.
REQ-006 The block SHALL have a port in_valid, input, 1 bit: in_col/in_addr carry one window column this cycle.
REQ-007 The block SHALL have a port in_col, input, 3*DATA_W bits: pixel rows 0..2 of one column, with row r at bits [r*DATA_W +: DATA_W].
REQ-008 The block SHALL have a port in_addr, input, 32 bits: destination address associated with the column (controller write address).
REQ-009 The block SHALL have a port row_start, input, 1 bit: qualified by in_valid; the accepted column starts a new image row.
REQ-010 The block SHALL have a port w_load, input, 1 bit: load the kernel from w_data this cycle.
REQ-011 The block SHALL have a port w_data, input, 9*DATA_W bits: kernel weight k=r*3+c at bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have a port out_valid, output, 1 bit: out_data/out_addr valid this cycle (single-cycle pulse per result).
REQ-013 The block SHALL have a port out_data, output, ACC_W bits: signed 3x3 dot product.
REQ-014 The block SHALL have a port out_addr, output, 32 bits: in_addr of the column that completed the window.

Function
REQ-015 A column SHALL be accepted when in_valid & en & ~w_load; an accepted column shifts into a 3-column window register, with window column 0 the oldest and column 2 the newest.
REQ-016 Fill state SHALL be a counter cnt in {EMPTY=0, ONE=1, TWO=2, FULL=3}: each accepted column advances the counter, saturating at FULL.
REQ-017 An accepted column with row_start=1 SHALL set cnt=ONE, discarding previous columns.
REQ-018 An accepted column that leaves cnt=FULL, whether the transition is TWO->FULL or FULL->FULL, SHALL fire the window.
REQ-019 On a fire, stage 1 SHALL register the nine signed products window[r][c]*w[r*3+c], each 2*DATA_W bits, together with in_addr.
REQ-020 Stage 2 SHALL register the signed sum of the nine products, sign-extended to ACC_W with no saturation, along with the address and valid.
REQ-021 Latency SHALL be fixed at 2: a fire on cycle N yields out_valid=1 on cycle N+2, and back-to-back fires SHALL give back-to-back results at 1 result per cycle.
REQ-022 The block SHALL apply no backpressure.
REQ-023 The pipeline SHALL keep draining while en=0 or no column arrives; in those cases out_valid=0 after drain.
REQ-024 w_load=1 SHALL capture all nine weights, set cnt=EMPTY, and drop any simultaneous in_valid column.
REQ-025 Products already in stage 1 or 2 when w_load=1 SHALL complete with the old weights.
REQ-026 out_data and out_addr SHALL hold their last values when out_valid=0.

Reset
REQ-027 While rst=1, asynchronously: out_valid=0, out_data=0, out_addr=0, cnt=EMPTY, window=0, all weights=0, pipeline valid bits=0.
REQ-028 Deassertion of rst SHALL take effect at the next clk edge; the first column accepted after reset SHALL be treated as a row start.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results, so no out_valid appears from pre-reset columns.

Verification
REQ-030 Scenario: load all weights=1, then columns (1,2,3),(4,5,6),(7,8,9) on consecutive cycles with in_addr 0x10,0x11,0x12 -> single out_valid 2 cycles after the third column, out_data=45, out_addr=0x12.
REQ-031 Scenario: continue with column (10,11,12), in_addr 0x13, in the following cycle -> out_valid on consecutive cycles, second result out_data=72, out_addr=0x13.
REQ-032 Scenario: center weight (k=4) = -1, others 0; window center pixel = -128 -> out_data=128, sign-correct in ACC_W.
REQ-033 Scenario: row_start=1 on the 4th column of a running row -> no out_valid until two further columns are accepted; the next result covers only the new row's columns.
REQ-034 Scenario: w_load=1 in the same cycle as in_valid=1 -> column dropped, cnt=EMPTY, and the next two accepted columns produce no output.
REQ-035 Scenario: assert rst one cycle after a fire -> out_valid stays 0 and all outputs read 0 during reset; after release and the same 3-column input, the bench sees the same result as the corresponding earlier scenario.
